// File: rtl/register_bank.sv
// register_bank: parametrised general-purpose register file with a per-register
// busy scoreboard.
//
// Register 0 always reads as zero with busy 0. Writes and reservations to
// address 0 are dropped. Busy bits track pending writes: a reservation sets
// one, and a write or a flush clears it. When several of these hit the same
// address in one cycle, a reservation wins over a flush, and a flush wins over
// a write-clear.
//
// Optional feature: define REGBANK_BYPASS_EN to forward same-cycle write data
// to matching read ports. A forwarded port also reports busy 0.
//
// Parameters:
//   DATA_W    register width in bits
//   ADDR_W    address width; depth = 2**ADDR_W
//   NUM_READ  number of combinational read ports (>= 1)
//
// Ports:
//   clk            clock, rising edge
//   resetN         asynchronous active-low reset; clears data and busy
//   readAddr       read addresses, port i at [i*ADDR_W +: ADDR_W]
//   readData       read data, port i at [i*DATA_W +: DATA_W]
//   readBusy       per-port busy flag of the addressed register
//   writeEnable    write strobe
//   writeReg       write address
//   writeData      write data
//   reserveEnable  mark reserveReg busy
//   reserveReg     address to reserve
//   flush          clear all busy bits
module register_bank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_READ = 2
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic [NUM_READ*ADDR_W-1:0]   readAddr,
    output logic [NUM_READ*DATA_W-1:0]   readData,
    output logic [NUM_READ-1:0]          readBusy,
    input  logic                         writeEnable,
    input  logic [ADDR_W-1:0]            writeReg,
    input  logic [DATA_W-1:0]            writeData,
    input  logic                         reserveEnable,
    input  logic [ADDR_W-1:0]            reserveReg,
    input  logic                         flush
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              write_hit;
    logic              reserve_hit;

    assign write_hit   = writeEnable && (writeReg != '0);
    assign reserve_hit = reserveEnable && (reserveReg != '0);

    // Data array. Flush does not touch the data.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_hit) begin
            regs_q[writeReg] <= writeData;
        end
    end

    // Later assignments win, which gives reserve > flush > write-clear.
    always_comb begin
        busy_d = busy_q;
        if (write_hit) begin
            busy_d[writeReg] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (reserve_hit) begin
            busy_d[reserveReg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Independent combinational read ports.
    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = readAddr[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs_q[addr];
            busy = busy_q[addr];
`ifdef REGBANK_BYPASS_EN
            if (write_hit && (addr == writeReg)) begin
                data = writeData;
                busy = 1'b0;
            end
`endif
            if (addr == '0) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign readData[p*DATA_W +: DATA_W] = data;
        assign readBusy[p]                  = busy;
    end

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

    // ---------------- DUT A: default parameters (32 x 32, 2 ports) ----------------
    logic        clk;
    logic        resetN;
    logic [9:0]  readAddr;
    logic [63:0] readData;
    logic [1:0]  readBusy;
    logic        writeEnable;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        reserveEnable;
    logic [4:0]  reserveReg;
    logic        flush;

    register_bank dut_a (
        .clk           (clk),
        .resetN        (resetN),
        .readAddr      (readAddr),
        .readData      (readData),
        .readBusy      (readBusy),
        .writeEnable   (writeEnable),
        .writeReg      (writeReg),
        .writeData     (writeData),
        .reserveEnable (reserveEnable),
        .reserveReg    (reserveReg),
        .flush         (flush)
    );

    // ---------------- DUT B: 16-bit data, 8 registers, 4 ports ----------------
    logic [11:0] b_readAddr;
    logic [63:0] b_readData;
    logic [3:0]  b_readBusy;
    logic        b_writeEnable;
    logic [2:0]  b_writeReg;
    logic [15:0] b_writeData;
    logic        b_reserveEnable;
    logic [2:0]  b_reserveReg;
    logic        b_flush;

    register_bank #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .NUM_READ (4)
    ) dut_b (
        .clk           (clk),
        .resetN        (resetN),
        .readAddr      (b_readAddr),
        .readData      (b_readData),
        .readBusy      (b_readBusy),
        .writeEnable   (b_writeEnable),
        .writeReg      (b_writeReg),
        .writeData     (b_writeData),
        .reserveEnable (b_reserveEnable),
        .reserveReg    (b_reserveReg),
        .flush         (b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        re;
        logic [4:0]  rreg;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                                input logic re, input logic [4:0] rreg, input logic fl,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic b0, input logic b1);
        vec_t v;
        v.we = we; v.wreg = wreg; v.wdata = wdata; v.re = re; v.rreg = rreg; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    // Apply one vector across a clock edge, then drop the strobes and compare.
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        writeEnable   = v.we;
        writeReg      = v.wreg;
        writeData     = v.wdata;
        reserveEnable = v.re;
        reserveReg    = v.rreg;
        flush         = v.fl;
        readAddr      = {v.ra1, v.ra0};
        @(posedge clk);
        #1;
        writeEnable   = 1'b0;
        reserveEnable = 1'b0;
        flush         = 1'b0;
        #1;
        check($sformatf("vec%0d data0", idx), 64'(readData[31:0]), 64'(v.d0));
        check($sformatf("vec%0d data1", idx), 64'(readData[63:32]), 64'(v.d1));
        check($sformatf("vec%0d busy0", idx), 64'(readBusy[0]), 64'(v.b0));
        check($sformatf("vec%0d busy1", idx), 64'(readBusy[1]), 64'(v.b1));
    endtask

    vec_t vecs [15];

    initial begin
        //            we wreg wdata         re rreg fl ra0 ra1 d0            d1            b0 b1
        vecs[0]  = mk(0, 0,  32'h0,        0, 0,  0, 0,  3,  32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(1, 5,  32'h12345678, 0, 0,  0, 5,  0,  32'h12345678, 32'h0,        0, 0);
        vecs[2]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  0, 5,  0,  32'h12345678, 32'h0,        0, 0);
        vecs[3]  = mk(0, 0,  32'h0,        1, 7,  0, 7,  5,  32'h0,        32'h12345678, 1, 0);
        vecs[4]  = mk(1, 7,  32'hA5,       0, 0,  0, 7,  5,  32'hA5,       32'h12345678, 0, 0);
        vecs[5]  = mk(1, 7,  32'hA5,       1, 7,  0, 7,  0,  32'hA5,       32'h0,        1, 0);
        vecs[6]  = mk(0, 0,  32'h0,        1, 2,  0, 2,  7,  32'h0,        32'hA5,       1, 1);
        vecs[7]  = mk(0, 0,  32'h0,        1, 9,  0, 9,  2,  32'h0,        32'h0,        1, 1);
        vecs[8]  = mk(0, 0,  32'h0,        1, 31, 0, 31, 9,  32'h0,        32'h0,        1, 1);
        vecs[9]  = mk(0, 0,  32'h0,        1, 4,  1, 4,  2,  32'h0,        32'h0,        1, 0);
        vecs[10] = mk(0, 0,  32'h0,        0, 0,  0, 9,  31, 32'h0,        32'h0,        0, 0);
        vecs[11] = mk(0, 0,  32'h0,        0, 0,  0, 7,  7,  32'hA5,       32'hA5,       0, 0);
        vecs[12] = mk(1, 7,  32'h1,        1, 0,  0, 0,  7,  32'h0,        32'h1,        0, 0);
        vecs[13] = mk(1, 4,  32'h44,       0, 0,  1, 4,  4,  32'h44,       32'h44,       0, 0);
        vecs[14] = mk(0, 0,  32'h0,        1, 4,  1, 4,  0,  32'h44,       32'h0,        1, 0);

        resetN = 1'b0;
        readAddr = '0; writeEnable = 0; writeReg = '0; writeData = '0;
        reserveEnable = 0; reserveReg = '0; flush = 0;
        b_readAddr = '0; b_writeEnable = 0; b_writeReg = '0; b_writeData = '0;
        b_reserveEnable = 0; b_reserveReg = '0; b_flush = 0;

        #1;
        check("reset data", readData, 64'h0);
        check("reset busy", 64'(readBusy), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i], i);
        end

        // Asynchronous reset mid-cycle clears data and busy with no clock edge.
        step(mk(1, 3, 32'hDEADBEEF, 1, 3, 0, 3, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1), 15);
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check("async reset data", readData, 64'h0);
        check("async reset busy", 64'(readBusy), 64'h0);
        @(negedge clk);
        resetN = 1'b1;

        // Same-cycle write and read of reg10 (which is busy beforehand).
        step(mk(1, 10, 32'h11, 0, 0, 0, 10, 0, 32'h11, 32'h0, 0, 0), 16);
        step(mk(0, 0, 32'h0, 1, 10, 0, 10, 0, 32'h11, 32'h0, 1, 0), 17);
        @(negedge clk);
        writeEnable = 1'b1;
        writeReg    = 5'd10;
        writeData   = 32'h55AA55AA;
        readAddr    = {5'd0, 5'd10};
        #1;
`ifdef REGBANK_BYPASS_EN
        check("bypass data pre-edge", 64'(readData[31:0]), 64'h55AA55AA);
        check("bypass busy pre-edge", 64'(readBusy[0]), 64'h0);
`else
        check("no-bypass data pre-edge", 64'(readData[31:0]), 64'h11);
        check("no-bypass busy pre-edge", 64'(readBusy[0]), 64'h1);
`endif
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        #1;
        check("bypass data post-edge", 64'(readData[31:0]), 64'h55AA55AA);
        check("bypass busy post-edge", 64'(readBusy[0]), 64'h0);

        // Four-port instance: all ports on addr 6.
        @(negedge clk);
        b_writeEnable = 1'b1;
        b_writeReg    = 3'd6;
        b_writeData   = 16'hBEEF;
        b_readAddr    = {3'd6, 3'd6, 3'd6, 3'd6};
        @(posedge clk);
        #1;
        b_writeEnable = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("b port%0d data", p), 64'(b_readData[p*16 +: 16]), 64'hBEEF);
        end
        check("b busy all", 64'(b_readBusy), 64'h0);

        // Write to addr 0 dropped; reserve 6 visible on all ports.
        @(negedge clk);
        b_writeEnable   = 1'b1;
        b_writeReg      = 3'd0;
        b_writeData     = 16'h1234;
        b_reserveEnable = 1'b1;
        b_reserveReg    = 3'd6;
        b_readAddr      = {3'd6, 3'd0, 3'd6, 3'd0};
        @(posedge clk);
        #1;
        b_writeEnable   = 1'b0;
        b_reserveEnable = 1'b0;
        #1;
        check("b addr0 data", b_readData, {16'hBEEF, 16'h0, 16'hBEEF, 16'h0});
        check("b addr0 busy", 64'(b_readBusy), 64'b1010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
